// File: rtl/leve1_id.sv
// ---------------------------------------------------------------------------
// leve1_id -- decode / operand-fetch stage.
//
// Accepts fetched instructions, reads rs1/rs2 from a 32-entry GPR file and the
// addressed CSR from a five-entry machine-mode CSR file, resolves data hazards,
// then registers PC, instruction and operands toward execute. It also owns
// architectural writeback of GPRs and CSRs from the execute stage's WB_* bus.
//
// Build option: define LEVE1_ID_FWD_EN to forward GPR results from execute
// (EX_FWD_RD) and writeback (WB_RD). Without it, a RAW hazard on rs1/rs2
// stalls until the producer has committed to the GPR file.
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   IVALID/IREADY       fetch handshake; IPC/IINSTR instruction and its PC
//   FLUSH               taken-branch kill from execute
//   OVALID/OREADY       handshake toward execute
//   OPC/OINSTR          registered PC / instruction
//   ORS1/ORS2/OCSR      registered rs1, rs2 and CSR[instr[31:20]] operands
//   EX_FWD_RD/EX_WE     execute result of the instruction held in OINSTR
//   WB_VALID/WB_INSTR   committing instruction
//   WB_WE/WB_RD/WB_CSRD commit write enable, GPR data, CSR operand
// ---------------------------------------------------------------------------
module leve1_id #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [XLEN-1:0] IPC,
  input  logic [31:0]     IINSTR,
  input  logic            FLUSH,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] OPC,
  output logic [31:0]     OINSTR,
  output logic [XLEN-1:0] ORS1,
  output logic [XLEN-1:0] ORS2,
  output logic [XLEN-1:0] OCSR,
  input  logic [XLEN-1:0] EX_FWD_RD,
  input  logic            EX_WE,
  input  logic            WB_VALID,
  input  logic [31:0]     WB_INSTR,
  input  logic            WB_WE,
  input  logic [XLEN-1:0] WB_RD,
  input  logic [XLEN-1:0] WB_CSRD
);

  // The CSR address map is fixed: mstatus, mtvec, mscratch, mepc, mcause.
  localparam int          NCSR_IMPL  = 5;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  typedef enum logic [6:0] {
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } csr_sel_t;

  function automatic logic is_csr_access(input logic [31:0] instr);
    return (instr[6:0] == OPC_SYSTEM) && (instr[14:12] != 3'b000);
  endfunction

  function automatic logic is_rd_writer(input logic [31:0] instr);
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM32, OPC_OP, OPC_LUI, OPC_AUIPC: return 1'b1;
      default: return is_csr_access(instr);
    endcase
  endfunction

  function automatic logic is_csr_writer(input logic [31:0] instr);
    return is_csr_access(instr) || (instr == INSTR_MRET);
  endfunction

  // MRET restores mstatus, so it is treated as a write to 0x300.
  function automatic logic [11:0] csr_target(input logic [31:0] instr);
    return (instr == INSTR_MRET) ? 12'h300 : instr[31:20];
  endfunction

  function automatic csr_sel_t csr_sel(input logic [11:0] addr);
    csr_sel_t s;
    s.hit = 1'b1;
    case (addr)
      12'h300: s.idx = 3'd0;
      12'h305: s.idx = 3'd1;
      12'h340: s.idx = 3'd2;
      12'h341: s.idx = 3'd3;
      12'h342: s.idx = 3'd4;
      default: begin
        s.hit = 1'b0;
        s.idx = 3'd0;
      end
    endcase
    return s;
  endfunction

  // State
  logic            ovalid_q, ovalid_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic [31:0]     oinstr_q, oinstr_d;
  logic [XLEN-1:0] ors1_q, ors1_d, ors2_q, ors2_d, ocsr_q, ocsr_d;
  logic [XLEN-1:0] gpr_q [32];
  logic [XLEN-1:0] gpr_d [32];
  logic [XLEN-1:0] csr_q [NCSR_IMPL];
  logic [XLEN-1:0] csr_d [NCSR_IMPL];

  // Decode-side fields and hazard terms
  logic [4:0]      rs1_a, rs2_a, ex_rd_a, wb_rd_a;
  logic            ex_wr, wb_wr, csr_stall, gpr_stall, stall, transfer;
  logic [XLEN-1:0] rs1_val, rs2_val, csr_rd_val;
  csr_sel_t        rd_sel, wb_sel;
  logic [1:0]      wb_cmd;
  logic [XLEN-1:0] csr_old, csr_new;
  logic            csr_we;

  assign rs1_a   = IINSTR[19:15];
  assign rs2_a   = IINSTR[24:20];
  assign ex_rd_a = oinstr_q[11:7];
  assign wb_rd_a = WB_INSTR[11:7];
  assign ex_wr   = ovalid_q && is_rd_writer(oinstr_q) && (ex_rd_a != 5'd0);
  assign wb_wr   = WB_VALID && WB_WE && is_rd_writer(WB_INSTR) && (wb_rd_a != 5'd0);

  // A CSR read waits until every in-flight writer of that CSR has committed,
  // so OCSR always comes straight from the CSR file.
  assign csr_stall = IVALID && is_csr_access(IINSTR) &&
    ((ovalid_q && is_csr_writer(oinstr_q) && (csr_target(oinstr_q) == IINSTR[31:20])) ||
     (WB_VALID && is_csr_writer(WB_INSTR) && (csr_target(WB_INSTR) == IINSTR[31:20])));

`ifdef LEVE1_ID_FWD_EN
  // Execute beats writeback: it holds the younger producer. ex_rd_a/wb_rd_a
  // are non-zero here, so a match also implies rs != x0.
  assign rs1_val = (ex_wr && EX_WE && (ex_rd_a == rs1_a)) ? EX_FWD_RD :
                   (wb_wr && (wb_rd_a == rs1_a))          ? WB_RD     : gpr_q[rs1_a];
  assign rs2_val = (ex_wr && EX_WE && (ex_rd_a == rs2_a)) ? EX_FWD_RD :
                   (wb_wr && (wb_rd_a == rs2_a))          ? WB_RD     : gpr_q[rs2_a];
  assign gpr_stall = 1'b0;
`else
  // The file is written on the same edge the decode samples, so a producer
  // still sitting in writeback must also be waited out.
  assign rs1_val   = gpr_q[rs1_a];
  assign rs2_val   = gpr_q[rs2_a];
  assign gpr_stall = IVALID &&
    ((ex_wr && ((ex_rd_a == rs1_a) || (ex_rd_a == rs2_a))) ||
     (wb_wr && ((wb_rd_a == rs1_a) || (wb_rd_a == rs2_a))));
  logic unused_fwd_ok;
  assign unused_fwd_ok = &{1'b0, EX_WE, EX_FWD_RD};
`endif

  assign stall    = csr_stall || gpr_stall;
  assign IREADY   = !stall && (!ovalid_q || OREADY);
  assign transfer = IVALID && IREADY;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_sel     = csr_sel(IINSTR[31:20]);
    csr_rd_val = '0;
    for (int i = 0; i < NCSR_IMPL; i++)
      if (rd_sel.hit && (rd_sel.idx == 3'(i))) csr_rd_val = csr_q[i];

    ovalid_d = ovalid_q;
    opc_d    = opc_q;
    oinstr_d = oinstr_q;
    ors1_d   = ors1_q;
    ors2_d   = ors2_q;
    ocsr_d   = ocsr_q;
    if (FLUSH) begin
      ovalid_d = 1'b0;
    end else if (transfer) begin
      ovalid_d = 1'b1;
      opc_d    = IPC;
      oinstr_d = IINSTR;
      ors1_d   = rs1_val;
      ors2_d   = rs2_val;
      ocsr_d   = csr_rd_val;
    end else if (OREADY) begin
      ovalid_d = 1'b0;
    end
  end

  // Architectural writeback of GPRs and CSRs.
  always_comb begin
    gpr_d = gpr_q;
    if (wb_wr) gpr_d[wb_rd_a] = WB_RD;

    wb_sel  = csr_sel(csr_target(WB_INSTR));
    wb_cmd  = (WB_INSTR == INSTR_MRET) ? 2'b01 : WB_INSTR[13:12];
    csr_old = '0;
    for (int i = 0; i < NCSR_IMPL; i++)
      if (wb_sel.idx == 3'(i)) csr_old = csr_q[i];

    csr_we  = WB_VALID && WB_WE && is_csr_writer(WB_INSTR) && wb_sel.hit;
    csr_new = csr_old;
    case (wb_cmd)
      2'b01: csr_new = WB_CSRD;
      2'b10: begin
        csr_new = csr_old | WB_CSRD;
        if (WB_INSTR[19:15] == 5'd0) csr_we = 1'b0;
      end
      2'b11: begin
        csr_new = csr_old & ~WB_CSRD;
        if (WB_INSTR[19:15] == 5'd0) csr_we = 1'b0;
      end
      default: csr_we = 1'b0;
    endcase

    csr_d = csr_q;
    for (int i = 0; i < NCSR_IMPL; i++)
      if (csr_we && (wb_sel.idx == 3'(i))) csr_d[i] = csr_new;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: both register files are reset because reset must leave every GPR and
  // CSR architecturally zero; the cost is a reset pin on each storage flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovalid_q <= 1'b0;
      opc_q    <= '0;
      oinstr_q <= INSTR_NOP;
      ors1_q   <= '0;
      ors2_q   <= '0;
      ocsr_q   <= '0;
      gpr_q    <= '{default: '0};
      csr_q    <= '{default: '0};
    end else begin
      ovalid_q <= ovalid_d;
      opc_q    <= opc_d;
      oinstr_q <= oinstr_d;
      ors1_q   <= ors1_d;
      ors2_q   <= ors2_d;
      ocsr_q   <= ocsr_d;
      gpr_q    <= gpr_d;
      csr_q    <= csr_d;
    end
  end

  assign OVALID = ovalid_q;
  assign OPC    = opc_q;
  assign OINSTR = oinstr_q;
  assign ORS1   = ors1_q;
  assign ORS2   = ors2_q;
  assign OCSR   = ocsr_q;

endmodule

// File: tb/tb_leve1_id.sv
// ---------------------------------------------------------------------------
// tb_leve1_id -- directed testbench for leve1_id. The bench plays the role of
// fetch and of the execute stage (EX_* / WB_* buses) cycle by cycle.
// ---------------------------------------------------------------------------
module tb_leve1_id;
  localparam int XLEN = 64;

  logic            CLK = 1'b0;
  logic            RST;
  logic            IVALID, IREADY, FLUSH, OVALID, OREADY, EX_WE, WB_VALID, WB_WE;
  logic [XLEN-1:0] IPC, OPC, ORS1, ORS2, OCSR, EX_FWD_RD, WB_RD, WB_CSRD;
  logic [31:0]     IINSTR, OINSTR, WB_INSTR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  leve1_id #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST),
    .IVALID(IVALID), .IREADY(IREADY), .IPC(IPC), .IINSTR(IINSTR),
    .FLUSH(FLUSH),
    .OVALID(OVALID), .OREADY(OREADY), .OPC(OPC), .OINSTR(OINSTR),
    .ORS1(ORS1), .ORS2(ORS2), .OCSR(OCSR),
    .EX_FWD_RD(EX_FWD_RD), .EX_WE(EX_WE),
    .WB_VALID(WB_VALID), .WB_INSTR(WB_INSTR), .WB_WE(WB_WE),
    .WB_RD(WB_RD), .WB_CSRD(WB_CSRD)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle writeback commit driven as the execute stage would.
  task automatic commit(input logic [31:0] instr, input logic [63:0] rd, input logic [63:0] csrd);
    WB_VALID = 1'b1; WB_WE = 1'b1; WB_INSTR = instr; WB_RD = rd; WB_CSRD = csrd;
    step();
    WB_VALID = 1'b0; WB_WE = 1'b0;
  endtask

  // Present one instruction that is expected to be accepted immediately.
  task automatic issue(input string tag, input logic [31:0] instr, input logic [63:0] pc);
    IVALID = 1'b1; IINSTR = instr; IPC = pc;
    #1;
    check({tag, "_iready"}, 64'(IREADY), 64'd1);
    step();
    IVALID = 1'b0;
    check({tag, "_ovalid"}, 64'(OVALID), 64'd1);
  endtask

  initial begin
    RST = 1'b1; IVALID = 1'b0; FLUSH = 1'b0; OREADY = 1'b1; EX_WE = 1'b0;
    WB_VALID = 1'b0; WB_WE = 1'b0; IPC = '0; IINSTR = 32'h0000_0013;
    EX_FWD_RD = '0; WB_INSTR = 32'h0000_0013; WB_RD = '0; WB_CSRD = '0;

    // Reset state
    #12;
    check("rst_ovalid", 64'(OVALID), 64'd0);
    check("rst_opc",    OPC, 64'd0);
    check("rst_oinstr", 64'(OINSTR), 64'h13);
    check("rst_ors1",   ORS1, 64'd0);
    check("rst_ors2",   ORS2, 64'd0);
    check("rst_ocsr",   OCSR, 64'd0);
    step();
    RST = 1'b0;
    step();

    // x5 = 0x55 via writeback, then add x6,x5,x0 reads it from the file
    commit(32'h0550_0293, 64'h55, 64'h0);
    issue("x5_read", 32'h0002_8333, 64'h40);
    check("x5_ors1", ORS1, 64'h55);
    check("x5_opc",  OPC, 64'h40);

    // Reset mid-stream while OVALID=1 takes effect without a clock edge
    RST = 1'b1;
    #1;
    check("midrst_ovalid", 64'(OVALID), 64'd0);
    check("midrst_oinstr", 64'(OINSTR), 64'h13);
    step();
    RST = 1'b0;
    step();
    issue("post_rst", 32'h0002_8333, 64'h44);
    check("post_rst_x5", ORS1, 64'd0);
    step();

    // Back-to-back RAW: addi x1,x0,5 ; add x2,x1,x1
    IVALID = 1'b1; IINSTR = 32'h0050_0093; IPC = 64'h100;
    #1;
    check("raw_a_iready", 64'(IREADY), 64'd1);
    step();
    check("raw_a_ovalid", 64'(OVALID), 64'd1);
    IINSTR = 32'h0010_8133; IPC = 64'h104; EX_WE = 1'b1; EX_FWD_RD = 64'd5;
    #1;
`ifdef LEVE1_ID_FWD_EN
    check("raw_fwd_iready", 64'(IREADY), 64'd1);
    step();
    IVALID = 1'b0; EX_WE = 1'b0;
    check("raw_fwd_ovalid", 64'(OVALID), 64'd1);
    check("raw_fwd_opc",    OPC, 64'h104);
    check("raw_fwd_ors1",   ORS1, 64'd5);
    check("raw_fwd_ors2",   ORS2, 64'd5);
    commit(32'h0050_0093, 64'd5, 64'h0);
`else
    check("raw_stall1_iready", 64'(IREADY), 64'd0);
    step();
    check("raw_bubble1", 64'(OVALID), 64'd0);
    EX_WE = 1'b0;
    WB_VALID = 1'b1; WB_WE = 1'b1; WB_INSTR = 32'h0050_0093; WB_RD = 64'd5;
    #1;
    check("raw_stall2_iready", 64'(IREADY), 64'd0);
    step();
    check("raw_bubble2", 64'(OVALID), 64'd0);
    WB_VALID = 1'b0; WB_WE = 1'b0;
    #1;
    check("raw_go_iready", 64'(IREADY), 64'd1);
    step();
    IVALID = 1'b0;
    check("raw_nofwd_ovalid", 64'(OVALID), 64'd1);
    check("raw_nofwd_opc",    OPC, 64'h104);
    check("raw_nofwd_ors1",   ORS1, 64'd5);
    check("raw_nofwd_ors2",   ORS2, 64'd5);
`endif
    step();

    // x0 target: addi x0,x0,7 commits; add x3,x0,x0 must read zeros even
    // with a second x0 commit in flight during the decode cycle.
    commit(32'h0070_0013, 64'd7, 64'h0);
    WB_VALID = 1'b1; WB_WE = 1'b1; WB_INSTR = 32'h0070_0013; WB_RD = 64'd7;
    issue("x0_tgt", 32'h0000_01B3, 64'h120);
    WB_VALID = 1'b0; WB_WE = 1'b0;
    check("x0_ors1", ORS1, 64'd0);
    check("x0_ors2", ORS2, 64'd0);
    step();

    // CSR hazard: csrrw x1,mscratch,x2 (x2=0xA5) ; csrrs x3,mscratch,x0
    commit(32'h0A50_0113, 64'hA5, 64'h0);
    issue("csrrw", 32'h3401_10F3, 64'h200);
    check("csrrw_ors1", ORS1, 64'hA5);
    check("csrrw_ocsr", OCSR, 64'h0);
    IVALID = 1'b1; IINSTR = 32'h3400_21F3; IPC = 64'h204;
    #1;
    check("csr_stall1_iready", 64'(IREADY), 64'd0);
    step();
    check("csr_bubble1", 64'(OVALID), 64'd0);
    WB_VALID = 1'b1; WB_WE = 1'b1; WB_INSTR = 32'h3401_10F3; WB_RD = 64'h0; WB_CSRD = 64'hA5;
    #1;
    check("csr_stall2_iready", 64'(IREADY), 64'd0);
    step();
    WB_VALID = 1'b0; WB_WE = 1'b0;
    #1;
    check("csr_go_iready", 64'(IREADY), 64'd1);
    step();
    IVALID = 1'b0;
    check("csrrs_ovalid", 64'(OVALID), 64'd1);
    check("csrrs_opc",    OPC, 64'h204);
    check("csrrs_ocsr",   OCSR, 64'hA5);
    step();
    // csrrs with rs1=x0 commits: mscratch must not change
    commit(32'h3400_21F3, 64'hA5, 64'h0);
    issue("mscratch_rd", 32'h3400_2073, 64'h210);
    check("mscratch_kept", OCSR, 64'hA5);
    step();

    // csrrc x0,mscratch,x5 with x5=0x0F: 0xA5 & ~0x0F = 0xA0
    commit(32'h3402_B073, 64'h0, 64'h0F);
    issue("csrrc_rd", 32'h3400_2073, 64'h214);
    check("csrrc_result", OCSR, 64'hA0);
    step();

    // MRET commit loads mstatus from WB_CSRD
    commit(32'h3020_0073, 64'h0, 64'h1880);
    issue("mret_rd", 32'h3000_2073, 64'h220);
    check("mret_mstatus", OCSR, 64'h1880);
    step();

    // Unimplemented CSR 0x7C0: write ignored, reads zero
    commit(32'h7C00_9073, 64'h0, 64'hFF);
    issue("unimpl_rd", 32'h7C00_2073, 64'h230);
    check("unimpl_ocsr", OCSR, 64'h0);
    step();

    // Backpressure: OREADY=0 holds the bundle for 3 cycles
    issue("bp", 32'h0010_0393, 64'h100);
    check("bp_opc", OPC, 64'h100);
    OREADY = 1'b0; IVALID = 1'b1; IINSTR = 32'h0010_0413; IPC = 64'h104;
    #1;
    check("bp_iready", 64'(IREADY), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold%0d_ovalid", i), 64'(OVALID), 64'd1);
      check($sformatf("bp_hold%0d_opc", i),    OPC, 64'h100);
      check($sformatf("bp_hold%0d_oinstr", i), 64'(OINSTR), 64'h0010_0393);
    end

    // FLUSH with IVALID=1: bundle dropped, the offered instruction never emitted
    FLUSH = 1'b1; OREADY = 1'b1;
    step();
    FLUSH = 1'b0; IVALID = 1'b0;
    check("flush_ovalid", 64'(OVALID), 64'd0);
    step();
    check("flush_after_ovalid", 64'(OVALID), 64'd0);
    check("flush_after_opc",    OPC, 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
